// File: rtl/traffic_pkg.sv
// Shared types and display constants for the traffic light controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package traffic_pkg;

    typedef enum logic [2:0] {
        RED         = 3'd0,
        GREEN       = 3'd1,
        GREEN_BLINK = 3'd2,
        YELLOW      = 3'd3,
        NIGHT       = 3'd4
    } state_t;

    localparam logic [6:0] ON    = 7'b1000000;
    localparam logic [6:0] OFF   = 7'b1111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    // Decimal glyph table; values above 9 are clamped to 9.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            default: g = 7'b0010000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/strobe_div.sv
// Free-running modulo-DIV counter producing a one-cycle strobe at count DIV-1.
module strobe_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic strobe
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (cnt == W'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign strobe = (cnt == W'(DIV - 1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic light controller with pedestrian request, night flashing mode and
// a four-digit multiplexed lamp/countdown display.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int BLINK_DIV   = 5_000_000,
    parameter int SCAN_DIV    = 50_000,
    parameter int T_RED       = 5,
    parameter int T_GREEN     = 5,
    parameter int T_BLINK     = 3,
    parameter int T_YELLOW    = 2,
    parameter int T_MIN_GREEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [6:0] seg_out,
    output logic [3:0] digit_out,
    output logic [2:0] state_out,
    output logic       ped_ack
);

    localparam logic [3:0] MIN_G = 4'(T_MIN_GREEN);

    state_t     state, state_n;
    logic [3:0] rem, rem_n;
    logic       ped_pending, pend_n, ack_n;
    logic       blink_phase;
    logic [1:0] scan_idx;
    logic       tick, blink_stb, scan_stb;
    logic       req_ok, pend_eff;
    logic       green_on, yellow_on, red_on;
    logic [6:0] seg_n;
    logic [3:0] digit_n;

    strobe_div #(.DIV(TICK_DIV))  u_tick  (.clk(clk), .reset(reset), .strobe(tick));
    strobe_div #(.DIV(BLINK_DIV)) u_blink (.clk(clk), .reset(reset), .strobe(blink_stb));
    strobe_div #(.DIV(SCAN_DIV))  u_scan  (.clk(clk), .reset(reset), .strobe(scan_stb));

    function automatic state_t next_of(input state_t s);
        case (s)
            RED:         return GREEN;
            GREEN:       return GREEN_BLINK;
            GREEN_BLINK: return YELLOW;
            default:     return RED;
        endcase
    endfunction

    function automatic logic [3:0] dur(input state_t s);
        case (s)
            GREEN:       return 4'(T_GREEN);
            GREEN_BLINK: return 4'(T_BLINK);
            YELLOW:      return 4'(T_YELLOW);
            default:     return 4'(T_RED);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RED;
            rem         <= 4'(T_RED);
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
            blink_phase <= 1'b0;
            scan_idx    <= 2'd0;
            seg_out     <= OFF;
            digit_out   <= 4'b1110;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            ped_pending <= pend_n;
            ped_ack     <= ack_n;
            if (blink_stb) blink_phase <= ~blink_phase;
            if (scan_stb)  scan_idx    <= scan_idx + 2'd1;
            seg_out     <= seg_n;
            digit_out   <= digit_n;
        end
    end

    // A request arriving this cycle already counts toward shortening green.
    assign req_ok   = ped_req && (state == GREEN || state == GREEN_BLINK || state == YELLOW);
    assign pend_eff = ped_pending || req_ok;

    always_comb begin
        state_n = state;
        rem_n   = rem;
        pend_n  = ped_pending;
        ack_n   = 1'b0;
        if (night_mode) begin
            state_n = NIGHT;
            pend_n  = 1'b0;
        end else if (state == NIGHT) begin
            state_n = RED;
            rem_n   = 4'(T_RED);
        end else begin
            if (req_ok) pend_n = 1'b1;
            if (state == GREEN && pend_eff && rem > MIN_G) begin
                rem_n = MIN_G;
            end else if (tick) begin
                if (rem == 4'd1) begin
                    state_n = next_of(state);
                    rem_n   = dur(next_of(state));
                    // Entering red serves the request; a same-cycle request is dropped.
                    if (next_of(state) == RED) begin
                        ack_n  = ped_pending;
                        pend_n = 1'b0;
                    end
                end else begin
                    rem_n = rem - 4'd1;
                end
            end
        end
    end

    assign green_on  = (state == GREEN) || (state == GREEN_BLINK && !blink_phase);
    assign yellow_on = (state == YELLOW) || (state == NIGHT && !blink_phase);
    assign red_on    = (state == RED);

    always_comb begin
        seg_n   = OFF;
        digit_n = 4'b1110;
        case (scan_idx)
            2'd0: begin seg_n = green_on  ? ON : OFF; digit_n = 4'b1110; end
            2'd1: begin seg_n = yellow_on ? ON : OFF; digit_n = 4'b1101; end
            2'd2: begin seg_n = red_on    ? ON : OFF; digit_n = 4'b1011; end
            default: begin
                seg_n   = (state == NIGHT) ? BLANK : digit_glyph(rem);
                digit_n = 4'b0111;
            end
        endcase
    end

    assign state_out = state;

endmodule
